// File: rtl/mul2x2_acc_if.sv
// Handshake bundle between the 2x2 multiplier, the product accumulator and
// its downstream consumer.
//   in_valid/in_ready/in_prod/in_last : product stream into the accumulator
//   out_valid/out_ready               : result handshake
//   out_sum/out_count/out_ovf         : burst result
// master: the environment (drives products, accepts results).
// slave : the accumulator.
interface mul2x2_acc_if #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mul2x2_acc.sv
// Product accumulator: sums a burst of up to LEN 4-bit products and presents
// the registered sum, term count and sticky overflow flag on a valid/ready port.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   clr  - synchronous abort, discards the current burst (wins over handshakes)
//   bus  - mul2x2_acc_if.slave: product input and result output handshakes
// Build option: define MUL2X2_ACC_SAT_EN to saturate the sum at 2^ACC_W-1
// instead of wrapping; handshake, latency and counts are unchanged.
module mul2x2_acc #(
  parameter int unsigned ACC_W = 8,
  parameter int unsigned LEN   = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  mul2x2_acc_if.slave  bus
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_add;

  // One extra bit so the carry-out is the overflow indication.
  assign sum   = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, bus.in_prod};
  assign carry = sum[ACC_W];

`ifdef MUL2X2_ACC_SAT_EN
  // Once saturated the sum stays pinned for the rest of the burst.
  assign acc_add = (carry || (&acc_q)) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = StAccum;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            acc_d = acc_add;
            cnt_d = cnt_q + CNT_W'(1);
            ovf_d = ovf_q | carry;
            if (bus.in_last || (cnt_q == CNT_W'(LEN - 1))) begin
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_d = StAccum;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StAccum;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result fields come straight from state registers; they only mean
  // anything while out_valid is high.
  assign bus.in_ready  = (state_q == StAccum);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul2x2_acc.sv
// Scoreboard bench for mul2x2_acc: a default instance (ACC_W=8) and a narrow
// instance (ACC_W=5) for overflow. Expected results are queued when a burst is
// issued and popped by per-instance monitors on each output handshake.
module tb_mul2x2_acc;

  typedef struct {
    logic [7:0] sum;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst;
  logic clr;

  int checks = 0;
  int errors = 0;

  exp_t q8[$];
  exp_t q5[$];

  mul2x2_acc_if #(.ACC_W(8), .CNT_W(4)) bus8 ();
  mul2x2_acc_if #(.ACC_W(5), .CNT_W(4)) bus5 ();

  mul2x2_acc #(.ACC_W(8), .LEN(4), .CNT_W(4)) dut8 (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus8)
  );

  mul2x2_acc #(.ACC_W(5), .LEN(4), .CNT_W(4)) dut5 (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .bus (bus5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Present one product and wait (bounded) until it is accepted.
  task automatic send(input bit sel, input logic [3:0] p, input logic last);
    bit done;
    done = 1'b0;
    if (sel) begin
      bus5.in_valid = 1'b1; bus5.in_prod = p; bus5.in_last = last;
    end else begin
      bus8.in_valid = 1'b1; bus8.in_prod = p; bus8.in_last = last;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = sel ? bus5.in_ready : bus8.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    if (sel) bus5.in_valid = 1'b0;
    else     bus8.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !clr && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) begin
        chk("unexpected_out8", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("sum8", bus8.out_sum, e.sum);
        chk("count8", bus8.out_count, e.cnt);
        chk("ovf8", bus8.out_ovf, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus5.out_valid && bus5.out_ready) begin
      if (q5.size() == 0) begin
        chk("unexpected_out5", 32'd1, 32'd0);
      end else begin
        e = q5.pop_front();
        chk("sum5", {3'b0, bus5.out_sum}, e.sum);
        chk("count5", bus5.out_count, e.cnt);
        chk("ovf5", bus5.out_ovf, e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst = 1'b1; clr = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_prod = '0; bus8.in_last = 1'b0; bus8.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_prod = '0; bus5.in_last = 1'b0; bus5.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_in_ready", bus8.in_ready, 1);
    chk("rst_out_valid", bus8.out_valid, 0);
    chk("rst_out_sum", bus8.out_sum, 0);
    chk("rst_out_count", bus8.out_count, 0);
    chk("rst_out_ovf", bus8.out_ovf, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Full burst 9,6,4,1 -> 20; valid right after the 4th accept
    q8.push_back('{sum: 8'd20, cnt: 4'd4, ovf: 1'b0});
    send(0, 4'd9, 0); send(0, 4'd6, 0); send(0, 4'd4, 0); send(0, 4'd1, 0);
    chk("full_out_valid", bus8.out_valid, 1);
    chk("full_in_ready_hold", bus8.in_ready, 0);
    @(posedge clk); #1;
    chk("full_in_ready_after", bus8.in_ready, 1);
    chk("full_out_valid_after", bus8.out_valid, 0);

    // Backpressure: result held, in_valid pulses ignored
    bus8.out_ready = 1'b0;
    q8.push_back('{sum: 8'd4, cnt: 4'd4, ovf: 1'b0});
    send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd1, 0);
    for (int i = 0; i < 3; i++) begin
      bus8.in_valid = 1'b1; bus8.in_prod = 4'd7;
      @(negedge clk);
      chk("bp_out_valid", bus8.out_valid, 1);
      chk("bp_out_sum", bus8.out_sum, 4);
      chk("bp_out_count", bus8.out_count, 4);
      chk("bp_in_ready", bus8.in_ready, 0);
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", bus8.out_valid, 0);

    // Short burst 3, 2(last) -> 5, count 2; also proves restart from 0
    q8.push_back('{sum: 8'd5, cnt: 4'd2, ovf: 1'b0});
    send(0, 4'd3, 0); send(0, 4'd2, 1);
    chk("short_out_valid", bus8.out_valid, 1);
    @(posedge clk); #1;

    // clr mid-burst beats a simultaneous accept
    send(0, 4'd9, 0); send(0, 4'd9, 0);
    clr = 1'b1; bus8.in_valid = 1'b1; bus8.in_prod = 4'd9; bus8.in_last = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0; bus8.in_valid = 1'b0;
    chk("clr_out_sum", bus8.out_sum, 0);
    chk("clr_out_count", bus8.out_count, 0);
    chk("clr_in_ready", bus8.in_ready, 1);
    q8.push_back('{sum: 8'd8, cnt: 4'd4, ovf: 1'b0});
    send(0, 4'd2, 0); send(0, 4'd2, 0); send(0, 4'd2, 0); send(0, 4'd2, 0);
    @(posedge clk); #1;

    // clr while holding a result: result dropped, no delivery
    bus8.out_ready = 1'b0;
    send(0, 4'd5, 1);
    chk("hold_before_clr", bus8.out_valid, 1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus8.out_ready = 1'b1;
    chk("clr_hold_out_valid", bus8.out_valid, 0);
    chk("clr_hold_in_ready", bus8.in_ready, 1);
    chk("clr_hold_out_sum", bus8.out_sum, 0);

    // Asynchronous reset mid-burst
    send(0, 4'd5, 0); send(0, 4'd5, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", bus8.out_valid, 0);
    chk("arst_in_ready", bus8.in_ready, 1);
    chk("arst_out_sum", bus8.out_sum, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    q8.push_back('{sum: 8'd4, cnt: 4'd4, ovf: 1'b0});
    send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd1, 0);
    @(posedge clk); #1;

    // Overflow on ACC_W=5: 36 wraps to 4, or saturates at 31
`ifdef MUL2X2_ACC_SAT_EN
    q5.push_back('{sum: 8'd31, cnt: 4'd4, ovf: 1'b1});
`else
    q5.push_back('{sum: 8'd4, cnt: 4'd4, ovf: 1'b1});
`endif
    send(1, 4'd9, 0); send(1, 4'd9, 0); send(1, 4'd9, 0); send(1, 4'd9, 0);
    chk("ovf5_out_valid", bus5.out_valid, 1);
    repeat (3) @(posedge clk);
    #1;

    chk("q8_drained", q8.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul2x2_acc.md
Name: mul2x2_acc

Overview:
- Product accumulator directly downstream of the 2x2 multiplier. Consumes its 4-bit products one per cycle over a valid/ready handshake.
- Sums a burst of up to LEN products into an ACC_W-bit accumulator and presents the registered sum, term count and overflow flag on an output valid/ready port.
- Forms the back end of the small dot-product / MAC path.

Parameters:
- ACC_W, 8, accumulator and out_sum width; must be >= 4.
- LEN, 4, maximum products per burst; must be >= 1.
- CNT_W, 4, width of the term counter and out_count; must hold LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous abort; discards the current burst.
- in_valid  input  1  in_prod / in_last valid.
- in_ready  output  1  block can accept a product this cycle.
- in_prod  input  4  unsigned product, 0..9.
- in_last  input  1  marks the final product of a short burst.
- out_valid  output  1  out_sum / out_count / out_ovf valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  accumulated sum.
- out_count  output  CNT_W  number of products in the burst.
- out_ovf  output  1  sticky: burst sum exceeded 2^ACC_W-1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, in_ready=1, out_sum=0, out_count=0, out_ovf=0.
- Reset mid-burst: everything returns to reset values immediately; any partial sum is lost.
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready.
  - On accept: acc <= acc + zero-extended in_prod, cnt <= cnt+1, ovf <= ovf | carry-out of the add.
  - If accepted with in_last=1, or cnt==LEN-1, go to HOLD. The final product is included in out_sum.
  - out_valid rises the cycle after the last accept (1-cycle latency).
- HOLD:
  - in_ready=0, out_valid=1.
  - out_sum=acc, out_count=cnt, out_ovf=ovf, all held stable while out_ready=0.
  - On out_ready=1: acc, cnt and ovf clear, go to ACCUM. in_ready=1 in the following cycle; there is no input/output overlap.
- Arithmetic:
  - The add is ACC_W+1 bits wide; out_sum wraps mod 2^ACC_W.
  - Once set, ovf stays 1 until the result is consumed, clr, or rst.
- clr (synchronous):
  - In either state, acc=0, cnt=0, ovf=0, next state ACCUM.
  - clr beats a simultaneous input accept: that product is dropped.
  - clr beats a simultaneous out_ready: the result is not counted as delivered; out_valid simply falls.
- in_last with LEN=1: every accept goes to HOLD.
- in_valid while in HOLD: ignored, no accept. Upstream must hold its data (standard valid/ready).
- in_prod values >9 are never produced upstream. The block adds them without checking.

Optional Feature:
- Macro: MUL2X2_ACC_SAT_EN.
- Defined: on carry-out, or when acc is already saturated, acc clamps to 2^ACC_W-1 and stays there for the rest of the burst. ovf is still set.
- Undefined: wrap-around mod 2^ACC_W as described above.
- Handshake, latency and count behaviour are identical in both builds.

Test Plan:
- Full burst, defaults: products 9,6,4,1 back-to-back, out_ready=1 → out_valid one cycle after 4th accept, out_sum=20, out_count=4, out_ovf=0; in_ready=1 the cycle after.
- Short burst: 3 then 2 with in_last=1 on 2 → out_sum=5, out_count=2, out_ovf=0.
- Overflow, ACC_W=5: 9,9,9,9 → out_sum=4, out_ovf=1 without macro; out_sum=31, out_ovf=1 with MUL2X2_ACC_SAT_EN.
- Backpressure: after burst 1,1,1,1 hold out_ready=0 for 3 cycles → out_valid=1, out_sum=4 stable, in_ready=0, in_valid pulses not accepted; out_ready=1 → next burst starts from 0.
- clr mid-burst: accept 9,9, then clr together with in_valid/in_prod=9 → that 9 dropped; then 2,2,2,2 → out_sum=8, out_count=4.
- Async reset mid-burst: accept 5,5, assert rst between clock edges → out_valid=0, in_ready=1 immediately; after release, 1,1,1,1 → out_sum=4.
